mem_ctrl: RTL and testbench



---
 rtl/mem_ctrl_pkg.sv | 8 +
 rtl/mem_ctrl_fetch_assembler.sv | 52 +++++
 rtl/mem_ctrl.sv | 74 +++++++
 tb/tb_mem_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: fetch FSM state encodings, zero constants and bus widths
package mem_ctrl_pkg;
  typedef enum logic [2:0] {MC_IDLE, MC_B0, MC_B1, MC_B2, MC_B3, MC_B4} mc_state_t;
  localparam int reg_bus_w = 32;
  localparam int byte_bus_w = 8;
  localparam logic [byte_bus_w-1:0] zero8 = '0;
  localparam logic [reg_bus_w-1:0] zero32 = '0;
endpackage

// File: rtl/mem_ctrl_fetch_assembler.sv
// mem_ctrl_fetch_assembler: sequences four byte reads per fetch and assembles a little-endian word
module mem_ctrl_fetch_assembler
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic [ADDR_W-1:0]     addr,
  input  logic                  flush,
  input  logic                  ce,
  input  logic [byte_bus_w-1:0] ram_din,
  output logic                  idle,
  output logic                  active,
  output logic [ADDR_W-1:0]     base,
  output logic [ADDR_W-1:0]     rd_addr,
  output logic [reg_bus_w-1:0]  inst,
  output logic                  done
);
  mc_state_t state, nxt;
  logic start, fin;
  logic [2:0] k;
  logic [23:0] asm_q;
  assign idle = state == MC_IDLE;
  assign active = state inside {MC_B0, MC_B1, MC_B2, MC_B3};
  assign k = state - MC_B0;
  assign rd_addr = base + ADDR_W'(k);
  // state register
  always_ff @(posedge clk)
    state <= rst ? MC_IDLE : nxt;
  // next state: MEM access or flush abandon any fetch in progress, B4 completes it
  always_comb begin
    start = idle && req && !ce && !flush;
    fin = state == MC_B4 && !ce && !flush;
    nxt = idle ? (start ? MC_B0 : MC_IDLE)
        : (ce || flush || state == MC_B4) ? MC_IDLE : mc_state_t'(state + 3'd1);
  end
  // latch base, shift in bytes 0..2, and publish the word with byte 3 from the RAM
  always_ff @(posedge clk)
    if (rst) begin
      base <= '0;
      asm_q <= '0;
      inst <= zero32;
      done <= 1'b0;
    end else begin
      done <= fin;
      if (start) base <= addr;
      if (state inside {MC_B1, MC_B2, MC_B3}) asm_q <= {ram_din, asm_q[23:8]};
      if (fin) inst <= {ram_din, asm_q};
    end
endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: MEM/fetch RAM port arbiter; MEMCTRL_FETCH_BUF_EN adds a one-entry fetch buffer
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int RAM_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     ma_addr_in,
  input  logic [byte_bus_w-1:0] ma_data_in,
  input  logic                  ma_rw_flag,
  input  logic                  ma_ce_flag,
  output logic [byte_bus_w-1:0] ma_data_out,
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  input  logic                  if_flush,
  output logic [reg_bus_w-1:0]  if_inst,
  output logic                  if_done,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [byte_bus_w-1:0] ram_dout,
  output logic                  ram_wr,
  input  logic [byte_bus_w-1:0] ram_din,
  output logic                  mem_busy
);
  if (RAM_LAT != 1) begin : g_lat_check
    $error("mem_ctrl: only RAM_LAT=1 is supported");
  end
  logic fa_req, fa_idle, fa_active, fa_done;
  logic [ADDR_W-1:0] fa_base, fa_addr;
  logic [reg_bus_w-1:0] fa_inst;
  mem_ctrl_fetch_assembler #(.ADDR_W(ADDR_W)) u_fa (
    .clk(clk), .rst(rst), .req(fa_req), .addr(if_addr), .flush(if_flush), .ce(ma_ce_flag),
    .ram_din(ram_din), .idle(fa_idle), .active(fa_active), .base(fa_base), .rd_addr(fa_addr),
    .inst(fa_inst), .done(fa_done)
  );
  assign mem_busy = ma_ce_flag;
  assign ma_data_out = ram_din;
  assign ram_addr = rst ? '0 : ma_ce_flag ? ma_addr_in : fa_active ? fa_addr : '0;
  assign ram_dout = (ma_ce_flag && !rst) ? ma_data_in : zero8;
  assign ram_wr = ma_ce_flag && ma_rw_flag && !rst;
`ifdef MEMCTRL_FETCH_BUF_EN
  logic buf_valid, hit, hit_q, wr_hit;
  logic [ADDR_W-1:0] buf_addr, chk_addr;
  logic [reg_bus_w-1:0] buf_inst;
  assign hit = fa_idle && if_req && !ma_ce_flag && !if_flush && buf_valid && if_addr == buf_addr;
  assign fa_req = if_req && !hit;
  assign chk_addr = fa_done ? fa_base : buf_addr;
  assign wr_hit = ma_ce_flag && ma_rw_flag && (ma_addr_in - chk_addr) < ADDR_W'(4);
  assign if_done = fa_done || hit_q;
  assign if_inst = hit_q ? buf_inst : fa_inst;
  // capture each completed fetch; a store into the buffered word invalidates it
  always_ff @(posedge clk)
    if (rst) begin
      buf_valid <= 1'b0;
      buf_addr <= '0;
      buf_inst <= zero32;
      hit_q <= 1'b0;
    end else begin
      hit_q <= hit;
      buf_valid <= fa_done ? !wr_hit : buf_valid && !wr_hit;
      if (fa_done) begin
        buf_addr <= fa_base;
        buf_inst <= fa_inst;
      end
    end
`else
  logic unused;
  assign unused = ^{fa_idle, fa_base};
  assign fa_req = if_req;
  assign if_done = fa_done;
  assign if_inst = fa_inst;
`endif
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed checks of MEM pass-through, fetch sequencing, preemption, flush and buffer
module tb_mem_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] ma_addr_in = '0;
  logic [7:0] ma_data_in = '0;
  logic ma_rw_flag = 1'b0;
  logic ma_ce_flag = 1'b0;
  logic [7:0] ma_data_out;
  logic if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic if_flush = 1'b0;
  logic [31:0] if_inst;
  logic if_done;
  logic [31:0] ram_addr;
  logic [7:0] ram_dout;
  logic ram_wr;
  logic [7:0] ram_din = '0;
  logic mem_busy;
  logic [7:0] mem [65536];
  int total = 0;
  int bad = 0;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .ma_addr_in(ma_addr_in), .ma_data_in(ma_data_in), .ma_rw_flag(ma_rw_flag),
    .ma_ce_flag(ma_ce_flag), .ma_data_out(ma_data_out), .if_req(if_req), .if_addr(if_addr),
    .if_flush(if_flush), .if_inst(if_inst), .if_done(if_done), .ram_addr(ram_addr),
    .ram_dout(ram_dout), .ram_wr(ram_wr), .ram_din(ram_din), .mem_busy(mem_busy)
  );

  always #5 clk = ~clk;

  // single-port RAM, one-cycle read latency, low 16 address bits decoded
  always @(posedge clk) begin
    if (ram_wr) mem[ram_addr[15:0]] <= ram_dout;
    ram_din <= mem[ram_addr[15:0]];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mem_write(input logic [31:0] a, input logic [7:0] d);
    ma_ce_flag = 1'b1;
    ma_rw_flag = 1'b1;
    ma_addr_in = a;
    ma_data_in = d;
    tick();
    ma_ce_flag = 1'b0;
    ma_rw_flag = 1'b0;
    ma_addr_in = '0;
    ma_data_in = '0;
  endtask

  task automatic fetch_run(input logic [31:0] base, input logic [31:0] exp, input string nm);
    for (int c = 1; c <= 6; c++) begin
      automatic logic [31:0] ea;
      tick();
      ea = (c <= 4) ? base + 32'(c - 1) : 32'h0;
      total++;
      if (ram_addr !== ea) begin
        bad++;
        $display("FAIL %s ram_addr cycle%0d got=%h want=%h", nm, c, ram_addr, ea);
      end
      total++;
      if (if_done !== (c == 6)) begin
        bad++;
        $display("FAIL %s if_done cycle%0d got=%b want=%b", nm, c, if_done, c == 6);
      end
    end
    total++;
    if (if_inst !== exp) begin
      bad++;
      $display("FAIL %s if_inst got=%h want=%h", nm, if_inst, exp);
    end
    if_req = 1'b0;
    tick();
    total++;
    if (if_done !== 1'b0) begin
      bad++;
      $display("FAIL %s done_pulse got=%b want=0", nm, if_done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++;
    if ({if_done, if_inst, ram_addr, ram_dout, ram_wr, mem_busy} !== '0) begin
      bad++;
      $display("FAIL reset outputs got=%b/%h/%h/%h/%b/%b want=all zero",
               if_done, if_inst, ram_addr, ram_dout, ram_wr, mem_busy);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_mem_store();
    logic [31:0] w = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) begin
      ma_ce_flag = 1'b1;
      ma_rw_flag = 1'b1;
      ma_addr_in = 32'h2000 + 32'(i);
      ma_data_in = w[8*i +: 8];
      #1;
      total++;
      if (ram_addr !== 32'h2000 + 32'(i) || ram_dout !== w[8*i +: 8] || ram_wr !== 1'b1 || mem_busy !== 1'b1) begin
        bad++;
        $display("FAIL store byte%0d got=%h/%h/%b/%b want=%h/%h/1/1", i, ram_addr, ram_dout, ram_wr,
                 mem_busy, 32'h2000 + 32'(i), w[8*i +: 8]);
      end
      tick();
    end
    ma_ce_flag = 1'b0;
    ma_rw_flag = 1'b0;
    #1;
    total++;
    if (ram_wr !== 1'b0 || ram_addr !== 32'h0 || ram_dout !== 8'h0 || mem_busy !== 1'b0) begin
      bad++;
      $display("FAIL store_idle got=%b/%h/%h/%b want=0/0/0/0", ram_wr, ram_addr, ram_dout, mem_busy);
    end
    for (int i = 0; i < 4; i++) begin
      ma_ce_flag = 1'b1;
      ma_addr_in = 32'h2000 + 32'(i);
      tick();
      total++;
      if (ma_data_out !== w[8*i +: 8]) begin
        bad++;
        $display("FAIL load byte%0d got=%h want=%h", i, ma_data_out, w[8*i +: 8]);
      end
    end
    ma_ce_flag = 1'b0;
    ma_addr_in = '0;
  endtask

  task automatic test_fetch();
    mem_write(32'h1000, 8'h13);
    mem_write(32'h1001, 8'h05);
    mem_write(32'h1002, 8'h00);
    mem_write(32'h1003, 8'h00);
    if_req = 1'b1;
    if_addr = 32'h1000;
    fetch_run(32'h1000, 32'h00000513, "fetch1000");
  endtask

  task automatic test_preempt();
    mem_write(32'h3000, 8'h11);
    mem_write(32'h3001, 8'h22);
    mem_write(32'h3002, 8'h33);
    mem_write(32'h3003, 8'h44);
    if_req = 1'b1;
    if_addr = 32'h3000;
    tick();
    tick();
    tick();
    ma_ce_flag = 1'b1;
    ma_addr_in = 32'h2001;
    #1;
    total++;
    if (ram_addr !== 32'h2001 || ram_wr !== 1'b0) begin
      bad++;
      $display("FAIL preempt_addr got=%h/%b want=00002001/0", ram_addr, ram_wr);
    end
    tick();
    total++;
    if (if_done !== 1'b0 || ma_data_out !== 8'hBE) begin
      bad++;
      $display("FAIL preempt_hold got=%b/%h want=0/be", if_done, ma_data_out);
    end
    tick();
    ma_ce_flag = 1'b0;
    ma_addr_in = '0;
    #1;
    total++;
    if (ram_addr !== 32'h0 || if_done !== 1'b0) begin
      bad++;
      $display("FAIL preempt_idle got=%h/%b want=0/0", ram_addr, if_done);
    end
    fetch_run(32'h3000, 32'h44332211, "restart3000");
  endtask

  task automatic test_flush_wrap();
    mem_write(32'hFFFFFFFE, 8'hA1);
    mem_write(32'hFFFFFFFF, 8'hB2);
    mem_write(32'h00000000, 8'hC3);
    mem_write(32'h00000001, 8'hD4);
    if_req = 1'b1;
    if_addr = 32'h2000;
    repeat (5) tick();
    if_flush = 1'b1;
    if_addr = 32'hFFFFFFFE;
    tick();
    total++;
    if (if_done !== 1'b0) begin
      bad++;
      $display("FAIL flush_b4 got=%b want=0", if_done);
    end
    if_flush = 1'b0;
    fetch_run(32'hFFFFFFFE, 32'hD4C3B2A1, "wrap");
  endtask

`ifdef MEMCTRL_FETCH_BUF_EN
  task automatic test_fetch_buf();
    if_req = 1'b1;
    if_addr = 32'h1000;
    fetch_run(32'h1000, 32'h00000513, "buf_fill");
    if_req = 1'b1;
    tick();
    total++;
    if (if_done !== 1'b1 || if_inst !== 32'h00000513 || ram_addr !== 32'h0) begin
      bad++;
      $display("FAIL buf_hit got=%b/%h/%h want=1/00000513/0", if_done, if_inst, ram_addr);
    end
    if_req = 1'b0;
    tick();
    total++;
    if (if_done !== 1'b0) begin
      bad++;
      $display("FAIL buf_hit_pulse got=%b want=0", if_done);
    end
    mem_write(32'h1002, 8'h00);
    if_req = 1'b1;
    fetch_run(32'h1000, 32'h00000513, "buf_invalidated");
  endtask
`endif

  task automatic test_reset_mid();
    if_req = 1'b1;
    if_addr = 32'h3000;
    tick();
    tick();
    tick();
    rst = 1'b1;
    ma_ce_flag = 1'b1;
    ma_rw_flag = 1'b1;
    ma_addr_in = 32'h5000;
    ma_data_in = 8'h77;
    tick();
    total++;
    if (if_done !== 1'b0 || ram_wr !== 1'b0 || ram_addr !== 32'h0 || ram_dout !== 8'h0 || mem_busy !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid got=%b/%b/%h/%h/%b want=0/0/0/0/1", if_done, ram_wr, ram_addr, ram_dout, mem_busy);
    end
    rst = 1'b0;
    ma_ce_flag = 1'b0;
    ma_rw_flag = 1'b0;
    ma_addr_in = '0;
    ma_data_in = '0;
    if_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if (if_done !== 1'b0) begin
        bad++;
        $display("FAIL reset_abort cycle%0d got=%b want=0", i, if_done);
      end
    end
    if_req = 1'b1;
    if_addr = 32'h1000;
    fetch_run(32'h1000, 32'h00000513, "after_reset");
  endtask

  initial begin
    test_reset();
    test_mem_store();
    test_fetch();
    test_preempt();
    test_flush_wrap();
`ifdef MEMCTRL_FETCH_BUF_EN
    test_fetch_buf();
`endif
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
